// File: rtl/word_byte_sequencer.sv
// Serializes a latched 32-bit word into 1..4 bytes through an external 4:1 byte mux,
// with valid/ready handshakes on both the word and byte sides.
module word_byte_sequencer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  input  logic [1:0]  word_len,
  output logic        word_ready,
  output logic [31:0] mux_datain,
  output logic [1:0]  mux_sel,
  input  logic [7:0]  mux_dataout,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  input  logic        byte_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  len_q, len_d;
  logic        done_q, done_d;

  assign word_ready = (state_q == StIdle) && !rst;
  assign busy       = (state_q == StSend) && !rst;
  assign byte_valid = (state_q == StSend) && !rst;
  assign byte_data  = mux_dataout;
  assign mux_datain = data_q;
  assign mux_sel    = sel_q;
  assign done       = done_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (word_valid && word_ready) begin
          state_d = StSend;
          data_d  = word_data;
          len_d   = word_len;
          sel_d   = MSB_FIRST ? word_len : 2'd0;
          cnt_d   = 2'd0;
        end
      end
      StSend: begin
        if (byte_ready) begin
          if (cnt_q == len_q) begin
            // Last byte: leave mux_sel on its final value instead of stepping past it.
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 2'd1;
            sel_d = MSB_FIRST ? (sel_q - 2'd1) : (sel_q + 2'd1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= 32'd0;
      sel_q   <= 2'd0;
      cnt_q   <= 2'd0;
      len_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_word_byte_sequencer.sv
// Directed bench: one LSB-first and one MSB-first instance, each wired to a modelled byte mux.
module tb_word_byte_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wv0, br0, ready0, bv0, busy0, done0;
  logic [31:0] wd0, datain0;
  logic [1:0]  wl0, sel0;
  logic [7:0]  dout0, bd0;

  logic        wv1, br1, ready1, bv1, busy1, done1;
  logic [31:0] wd1, datain1;
  logic [1:0]  wl1, sel1;
  logic [7:0]  dout1, bd1;

  assign dout0 = datain0[{sel0, 3'b000} +: 8];
  assign dout1 = datain1[{sel1, 3'b000} +: 8];

  word_byte_sequencer #(.MSB_FIRST(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .word_valid(wv0), .word_data(wd0), .word_len(wl0),
    .word_ready(ready0), .mux_datain(datain0), .mux_sel(sel0), .mux_dataout(dout0),
    .byte_valid(bv0), .byte_data(bd0), .byte_ready(br0), .busy(busy0), .done(done0)
  );

  word_byte_sequencer #(.MSB_FIRST(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .word_valid(wv1), .word_data(wd1), .word_len(wl1),
    .word_ready(ready1), .mux_datain(datain1), .mux_sel(sel1), .mux_dataout(dout1),
    .byte_valid(bv1), .byte_data(bd1), .byte_ready(br1), .busy(busy1), .done(done1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_a [4];
  logic [31:0] b2b_words [3];

  initial begin
    rst = 1'b1;
    wv0 = 1'b0; wd0 = 32'd0; wl0 = 2'd0; br0 = 1'b1;
    wv1 = 1'b0; wd1 = 32'd0; wl1 = 2'd0; br1 = 1'b1;
    tick();
    tick();
    check_eq("rst_word_ready", ready0, 1'b0);
    check_eq("rst_byte_valid", bv0, 1'b0);
    check_eq("rst_busy", busy0, 1'b0);
    check_eq("rst_done", done0, 1'b0);
    check_eq("rst_datain", datain0, 32'd0);
    check_eq("rst_sel", sel0, 2'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", ready0, 1'b1);

    // LSB-first, 4 bytes, no stall; word_data changed after accept.
    wv0 = 1'b1; wd0 = 32'hA1B2C3D4; wl0 = 2'd3;
    tick();
    wv0 = 1'b0; wd0 = 32'hFFFFFFFF; wl0 = 2'd0;
    exp_a[0] = 8'hD4; exp_a[1] = 8'hC3; exp_a[2] = 8'hB2; exp_a[3] = 8'hA1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("a_valid%0d", i), bv0, 1'b1);
      check_eq($sformatf("a_byte%0d", i), bd0, exp_a[i]);
      check_eq($sformatf("a_sel%0d", i), sel0, i[1:0]);
      check_eq($sformatf("a_ready%0d", i), ready0, 1'b0);
      check_eq($sformatf("a_done%0d", i), done0, 1'b0);
      tick();
    end
    check_eq("a_done", done0, 1'b1);
    check_eq("a_ready_back", ready0, 1'b1);
    check_eq("a_valid_off", bv0, 1'b0);
    check_eq("a_sel_final", sel0, 2'd3);
    tick();
    check_eq("a_done_pulse", done0, 1'b0);

    // Stall on the second byte.
    wv0 = 1'b1; wd0 = 32'hCAFEBABE; wl0 = 2'd3;
    tick();
    wv0 = 1'b0;
    check_eq("s_byte0", bd0, 8'hBE);
    tick();
    br0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("s_hold_valid%0d", i), bv0, 1'b1);
      check_eq($sformatf("s_hold_byte%0d", i), bd0, 8'hBA);
      tick();
    end
    br0 = 1'b1;
    check_eq("s_byte1", bd0, 8'hBA);
    check_eq("s_valid1", bv0, 1'b1);
    tick();
    check_eq("s_byte2", bd0, 8'hFE);
    tick();
    check_eq("s_byte3", bd0, 8'hCA);
    tick();
    check_eq("s_done", done0, 1'b1);
    check_eq("s_valid_off", bv0, 1'b0);

    // word_valid held during SEND: second word waits for IDLE.
    wv0 = 1'b1; wd0 = 32'h12345678; wl0 = 2'd1;
    tick();
    wd0 = 32'h55AA55AA;
    check_eq("h_byte0", bd0, 8'h78);
    check_eq("h_ready0", ready0, 1'b0);
    tick();
    check_eq("h_byte1", bd0, 8'h56);
    check_eq("h_datain_kept", datain0, 32'h12345678);
    tick();
    check_eq("h_done", done0, 1'b1);
    check_eq("h_ready_idle", ready0, 1'b1);
    check_eq("h_bubble_valid", bv0, 1'b0);
    tick();
    wv0 = 1'b0;
    check_eq("h2_datain", datain0, 32'h55AA55AA);
    check_eq("h2_byte0", bd0, 8'hAA);
    tick();
    check_eq("h2_byte1", bd0, 8'h55);
    tick();
    check_eq("h2_done", done0, 1'b1);

    // Reset mid-word aborts without done.
    wv0 = 1'b1; wd0 = 32'hDEADBEEF; wl0 = 2'd3;
    tick();
    wv0 = 1'b0;
    check_eq("r_byte0", bd0, 8'hEF);
    tick();
    check_eq("r_byte1", bd0, 8'hBE);
    tick();
    rst = 1'b1;
    #1;
    check_eq("r_valid_in_rst", bv0, 1'b0);
    check_eq("r_busy_in_rst", busy0, 1'b0);
    check_eq("r_ready_in_rst", ready0, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("r_no_done", done0, 1'b0);
    check_eq("r_ready_after", ready0, 1'b1);
    check_eq("r_datain_cleared", datain0, 32'd0);
    wv0 = 1'b1; wd0 = 32'h01020304; wl0 = 2'd0;
    tick();
    wv0 = 1'b0;
    check_eq("r1_valid", bv0, 1'b1);
    check_eq("r1_byte", bd0, 8'h04);
    tick();
    check_eq("r1_done", done0, 1'b1);
    check_eq("r1_valid_off", bv0, 1'b0);

    // Back-to-back single-byte words, word_valid held high.
    b2b_words[0] = 32'h000000A5;
    b2b_words[1] = 32'h0000005A;
    b2b_words[2] = 32'h0000003C;
    wv0 = 1'b1; wl0 = 2'd0;
    for (int k = 0; k < 3; k++) begin
      wd0 = b2b_words[k];
      tick();
      check_eq($sformatf("b_valid%0d", k), bv0, 1'b1);
      check_eq($sformatf("b_byte%0d", k), bd0, b2b_words[k][7:0]);
      check_eq($sformatf("b_ready_busy%0d", k), ready0, 1'b0);
      tick();
      check_eq($sformatf("b_done%0d", k), done0, 1'b1);
      check_eq($sformatf("b_gap%0d", k), bv0, 1'b0);
    end
    wv0 = 1'b0;
    tick();
    check_eq("b_done_end", done0, 1'b0);

    // MSB-first, 2 bytes.
    wv1 = 1'b1; wd1 = 32'h11223344; wl1 = 2'd1;
    tick();
    wv1 = 1'b0;
    check_eq("m_byte0", bd1, 8'h33);
    check_eq("m_sel0", sel1, 2'd1);
    tick();
    check_eq("m_byte1", bd1, 8'h44);
    check_eq("m_sel1", sel1, 2'd0);
    check_eq("m_done_early", done1, 1'b0);
    tick();
    check_eq("m_done", done1, 1'b1);
    check_eq("m_sel_final", sel1, 2'd0);

    // MSB-first, 3 bytes: byte 3 never selected.
    wv1 = 1'b1; wd1 = 32'hAABBCCDD; wl1 = 2'd2;
    tick();
    wv1 = 1'b0;
    check_eq("m3_byte0", bd1, 8'hBB);
    tick();
    check_eq("m3_byte1", bd1, 8'hCC);
    tick();
    check_eq("m3_byte2", bd1, 8'hDD);
    check_eq("m3_sel2", sel1, 2'd0);
    tick();
    check_eq("m3_done", done1, 1'b1);
    check_eq("m3_valid_off", bv1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/word_byte_sequencer.md
WORD_BYTE_SEQUENCER -- requirements
Module: word_byte_sequencer

Interface
REQ-001 Parameter: MSB_FIRST, default 0; 0 = byte 0 (bits 7:0) sent first, 1 = highest selected byte sent first.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: word_valid  input  1  upstream word offer.
REQ-005 Port: word_data  input  32  word to serialize.
REQ-006 Port: word_len  input  2  number of bytes to send minus 1 (0 = 1 byte, 3 = 4 bytes).
REQ-007 Port: word_ready  output  1  block can accept a word.
REQ-008 Port: mux_datain  output  32  latched word, drives the 4:1 byte mux data input.
REQ-009 Port: mux_sel  output  2  byte select, drives the byte mux select.
REQ-010 Port: mux_dataout  input  8  selected byte returned from the byte mux.
REQ-011 Port: byte_valid  output  1  byte_data holds a valid byte.
REQ-012 Port: byte_data  output  8  outgoing byte.
REQ-013 Port: byte_ready  input  1  downstream accepts byte.
REQ-014 Port: busy  output  1  word in progress.
REQ-015 Port: done  output  1  one-cycle pulse after the last byte of a word is accepted.

Function
REQ-016 Two states SHALL exist: IDLE and SEND; state, index and counter SHALL be registered.
REQ-017 word_ready SHALL equal (state == IDLE) and !rst; busy SHALL equal (state == SEND).
REQ-018 Word accept: word_valid && word_ready at edge N -> latch word_data into mux_datain, latch word_len, go SEND at N+1.
REQ-019 On accept, mux_sel SHALL load 0 if MSB_FIRST = 0, else word_len; byte counter SHALL load 0.
REQ-020 byte_valid SHALL be 1 exactly when state == SEND; first byte valid the cycle after accept (latency 1).
REQ-021 byte_data SHALL be mux_dataout passed through combinationally; mux_sel and mux_datain SHALL be held stable while byte_valid && !byte_ready.
REQ-022 Byte transfer: byte_valid && byte_ready at an edge; counter += 1; mux_sel += 1 (MSB_FIRST = 0) or -= 1 (MSB_FIRST = 1), 2-bit arithmetic.
REQ-023 Last byte: transfer when counter == latched word_len -> state IDLE, done = 1 for the next cycle only; mux_sel SHALL keep its final value (no wrap effect observable).
REQ-024 Stall: byte_ready low for any number of cycles SHALL neither drop byte_valid nor change byte_data.
REQ-025 word_valid while SEND SHALL be ignored (word_ready = 0); new word accepted no earlier than the cycle after return to IDLE (one bubble cycle per word).
REQ-026 Throughput with byte_ready tied 1: word of L+1 bytes occupies L+2 cycles from accept to next word_ready.
REQ-027 word_data/word_len changes after accept SHALL not affect the word in progress.
REQ-028 MSB_FIRST = 1, word_len < 3: bytes word_len down to 0 sent; upper bytes never selected.

Reset
REQ-029 While rst = 1 at an edge: state IDLE, mux_sel 0, mux_datain 0, counter 0, latched length 0, done 0.
REQ-030 During rst = 1: word_ready 0, byte_valid 0, busy 0; no word accepted in the rst cycle.
REQ-031 rst asserted mid-word SHALL abort the word with no done pulse; remaining bytes discarded.
REQ-032 First cycle after rst deasserts: word_ready = 1.

Verification
REQ-033 MSB_FIRST=0, word 0xA1B2C3D4, len 3, byte_ready=1 -> bytes D4,C3,B2,A1 on 4 consecutive cycles, mux_sel 0,1,2,3, done at cycle 5, word_ready again at cycle 5.
REQ-034 MSB_FIRST=1, word 0x11223344, len 1 -> bytes 33,44; mux_sel 1,0; done after second byte.
REQ-035 Word 0xCAFEBABE len 3, byte_ready low 3 cycles on second byte -> BA held with byte_valid=1 for 4 cycles, then FE, CA; no duplicate/lost byte.
REQ-036 word_valid held with new word 0x55AA55AA during SEND of prior word -> ignored until IDLE, then accepted; output sequence of both words intact.
REQ-037 rst pulsed after second byte of 4-byte word -> byte_valid 0 and no done; next word 0x01020304 len 0 yields single byte 04.
REQ-038 Back-to-back 1-byte words with word_valid always high -> one byte every 2 cycles, done each word.
